ppr_sequencer: RTL



---
 rtl/ppr_pkg.sv | 48 ++++
 rtl/ppr_wait_cnt.sv | 31 +++
 rtl/ppr_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ppr_pkg.sv
// ppr_pkg: shared types and constants for the post-package-repair sequencer.
//   ppr_op_e    - command opcodes driven on the controller command port
//   ppr_type_e  - repair request type codes (other codes are invalid)
//   ppr_state_e - sequencer FSM states
//   GUARD_KEY   - guard-key bytes issued, in index order, before a hard repair
package ppr_pkg;

  typedef enum logic [2:0] {
    OP_NONE        = 3'd0,
    OP_MRS_PPR_EN  = 3'd1,
    OP_GUARD       = 3'd2,
    OP_ACT         = 3'd3,
    OP_PRE         = 3'd4,
    OP_MRS_PPR_DIS = 3'd5
  } ppr_op_e;

  typedef enum logic [1:0] {
    SOFT = 2'b01,
    HARD = 2'b10
  } ppr_type_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ENTER,
    ST_GUARD,
    ST_ACT,
    ST_PGM,
    ST_PRE,
    ST_EXIT,
    ST_DONE,
    ST_GAP
  } ppr_state_e;

  localparam logic [7:0] GUARD_KEY [4] = '{8'hCF, 8'h73, 8'hBB, 8'h3B};

  // Opcode issued by each command state; non-command states map to OP_NONE.
  function automatic ppr_op_e state_op(input ppr_state_e st);
    case (st)
      ST_ENTER: return OP_MRS_PPR_EN;
      ST_GUARD: return OP_GUARD;
      ST_ACT:   return OP_ACT;
      ST_PRE:   return OP_PRE;
      ST_EXIT:  return OP_MRS_PPR_DIS;
      default:  return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ppr_wait_cnt.sv
// ppr_wait_cnt: loadable down-counter with a zero flag. It saturates at zero,
// so after a load of V the flag is seen high V cycles later.
//   clk, rst     - clock, asynchronous active-high reset
//   load_i       - load load_val_i on this edge
//   load_val_i   - value to load
//   zero_o       - counter currently holds zero
module ppr_wait_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/ppr_sequencer.sv
// ppr_sequencer: per-device post-package-repair command sequencer.
// Accepts one repair request at a time, drives the fixed repair command
// sequence (PPR enable, guard keys for hard repair, ACT, program wait, PRE,
// PPR disable) onto the controller command port and pulses done with status.
//   clk, rst                   - clock, asynchronous active-high reset
//   req_valid_i / req_ready_o  - request handshake (ready only in IDLE)
//   req_type_i, req_addr_i, req_ch_i - repair type, faulty address, channel
//   cmd_valid_o / cmd_ready_i  - command handshake
//   cmd_op_o, cmd_ch_o, cmd_row_o, cmd_data_o - command fields
//   busy_o                     - sequence in progress
//   done_o, done_err_o, done_ch_o - completion pulse, error status, channel
module ppr_sequencer
  import ppr_pkg::*;
#(
  parameter int N_CH       = 32,
  parameter int ADDR_SIZE  = 24,
  parameter int ROW_SIZE   = 14,
  parameter int T_GAP      = 4,    // must be >= 1
  parameter int T_PGM_SOFT = 64,
  parameter int T_PGM_HARD = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_type_i,
  input  logic [ADDR_SIZE-1:0]    req_addr_i,
  input  logic [$clog2(N_CH)-1:0] req_ch_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic [2:0]              cmd_op_o,
  output logic [$clog2(N_CH)-1:0] cmd_ch_o,
  output logic [ROW_SIZE-1:0]     cmd_row_o,
  output logic [7:0]              cmd_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    done_err_o,
  output logic [$clog2(N_CH)-1:0] done_ch_o
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(T_PGM_HARD + 1);

  // The counter is loaded on the handshake edge and the wait state exits on
  // the cycle it reads zero, so loading N-1 yields exactly N wait cycles.
  localparam logic [CNT_W-1:0] GAP_LOAD      = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] PGM_SOFT_LOAD = CNT_W'(T_PGM_SOFT - 1);
  localparam logic [CNT_W-1:0] PGM_HARD_LOAD = CNT_W'(T_PGM_HARD - 1);

  ppr_state_e          r_state;
  ppr_state_e          r_after_gap;   // command state entered when GAP ends
  logic                r_hard;
  logic [ROW_SIZE-1:0] r_row;
  logic [CH_W-1:0]     r_ch;
  logic [1:0]          r_guard_idx;

  logic                r_req_ready;
  logic                r_cmd_valid;
  ppr_op_e             r_cmd_op;
  logic [ROW_SIZE-1:0] r_cmd_row;
  logic [7:0]          r_cmd_data;
  logic                r_busy;
  logic                r_done;
  logic                r_done_err;
  logic [CH_W-1:0]     r_done_ch;

  logic                w_accept;
  logic                w_type_ok;
  logic                w_cmd_hs;
  logic                w_cnt_zero;
  logic [CNT_W-1:0]    w_cnt_load_val;
  logic                w_addr_unused;

  assign w_accept  = req_valid_i & r_req_ready;
  assign w_type_ok = (req_type_i == SOFT) || (req_type_i == HARD);
  // cmd_ready_i is meaningless unless a command is actually presented.
  assign w_cmd_hs  = r_cmd_valid & cmd_ready_i;

  // Only the row field of the address is used by the repair sequence.
  assign w_addr_unused = ^req_addr_i[ADDR_SIZE-ROW_SIZE-1:0];

  always_comb begin
    w_cnt_load_val = GAP_LOAD;
    if (r_state == ST_ACT) begin
      w_cnt_load_val = r_hard ? PGM_HARD_LOAD : PGM_SOFT_LOAD;
    end
  end

  ppr_wait_cnt #(
    .W(CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_cmd_hs),
    .load_val_i (w_cnt_load_val),
    .zero_o     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_after_gap <= ST_IDLE;
      r_hard      <= 1'b0;
      r_row       <= '0;
      r_ch        <= '0;
      r_guard_idx <= 2'd0;
      r_req_ready <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_NONE;
      r_cmd_row   <= '0;
      r_cmd_data  <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_err  <= 1'b0;
      r_done_ch   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_done_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_hard      <= (req_type_i == HARD);
            r_row       <= req_addr_i[ADDR_SIZE-1 -: ROW_SIZE];
            r_ch        <= req_ch_i;
            r_guard_idx <= 2'd0;
            if (w_type_ok) begin
              r_state     <= ST_ENTER;
              r_cmd_valid <= 1'b1;
              r_cmd_op    <= OP_MRS_PPR_EN;
            end else begin
              // Invalid type: report an error completion without touching
              // the command port.
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_done_err <= 1'b1;
              r_done_ch  <= req_ch_i;
            end
          end
        end

        ST_ENTER, ST_GUARD, ST_ACT, ST_PRE, ST_EXIT: begin
          if (w_cmd_hs) begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_NONE;
            r_cmd_row   <= '0;
            r_cmd_data  <= 8'h00;
            r_state     <= ST_GAP;
            case (r_state)
              ST_ENTER: r_after_gap <= r_hard ? ST_GUARD : ST_ACT;
              ST_GUARD: begin
                r_after_gap <= (r_guard_idx == 2'd3) ? ST_ACT : ST_GUARD;
                r_guard_idx <= r_guard_idx + 2'd1;
              end
              ST_ACT:   r_state <= ST_PGM;
              ST_PRE:   r_after_gap <= ST_EXIT;
              default: begin
                // EXIT: no trailing gap, complete on the next cycle.
                r_state   <= ST_DONE;
                r_done    <= 1'b1;
                r_done_ch <= r_ch;
              end
            endcase
          end
        end

        ST_GAP: begin
          if (w_cnt_zero) begin
            r_state     <= r_after_gap;
            r_cmd_valid <= 1'b1;
            r_cmd_op    <= state_op(r_after_gap);
            r_cmd_row   <= (r_after_gap == ST_ACT) ? r_row : '0;
            r_cmd_data  <= (r_after_gap == ST_GUARD) ? GUARD_KEY[r_guard_idx] : 8'h00;
          end
        end

        ST_PGM: begin
          if (w_cnt_zero) begin
            r_state     <= ST_PRE;
            r_cmd_valid <= 1'b1;
            r_cmd_op    <= OP_PRE;
          end
        end

        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_done_ch   <= '0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign cmd_valid_o = r_cmd_valid;
  assign cmd_op_o    = r_cmd_op;
  // Channel is qualified by cmd_valid_o; it only changes at request accept,
  // so it is stable throughout every command.
  assign cmd_ch_o    = r_ch;
  assign cmd_row_o   = r_cmd_row;
  assign cmd_data_o  = r_cmd_data;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign done_err_o  = r_done_err;
  assign done_ch_o   = r_done_ch;

endmodule
